// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 {a,b,c,d} vectors into a 4-input function,
// holds each for SETTLE_CYCLES+1 cycles, and captures f into a truth table and ones count.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_f_in,
  output logic        o_a,
  output logic        o_b,
  output logic        o_c,
  output logic        o_d,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_table_out,
  output logic [4:0]  o_ones_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [3:0] LAST_WAIT = 4'(SETTLE_CYCLES - 1);
  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [3:0]  r_wait;
  logic [15:0] r_table;
  logic [4:0]  r_ones;
  logic        r_busy;
  logic        w_accept;
  logic        w_sample;
  logic        w_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // abort outranks both start and the SAMPLE capture
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_sample = 1'b0;
    w_count  = 1'b0;
    unique case (r_state)
      IDLE: if (i_start && !i_abort) begin
        w_next   = SETTLE;
        w_accept = 1'b1;
      end
      SETTLE: if (i_abort) w_next = IDLE;
        else if (r_wait == LAST_WAIT) w_next = SAMPLE;
        else w_count = 1'b1;
      SAMPLE: if (i_abort) w_next = IDLE;
        else begin
          w_sample = 1'b1;
          w_next   = (r_idx == 4'd15) ? DONE : SETTLE;
        end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_wait  <= '0;
      r_table <= '0;
      r_ones  <= '0;
      r_busy  <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_wait  <= '0;
      r_table <= '0;
      r_ones  <= '0;
      r_busy  <= 1'b1;
    end else begin
      if (w_next == IDLE) r_busy <= 1'b0;
      if (w_count) r_wait <= r_wait + 4'd1;
      if (w_sample) begin
        r_table[r_idx] <= i_f_in;
        r_ones         <= r_ones + {4'd0, i_f_in};
        if (r_idx != 4'd15) begin
          r_idx  <= r_idx + 4'd1;
          r_wait <= '0;
        end
      end
    end
  end
  assign {o_a, o_b, o_c, o_d} = r_idx;
  assign o_busy       = r_busy;
  assign o_done       = (r_state == DONE);
  assign o_table_out  = r_table;
  assign o_ones_count = r_ones;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps on two instances (settle 2 and settle 1)
// with a scoreboard of expected tables popped when done is seen.
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   sel = 0;
  int   mode = 0;
  int   tests = 0;
  int   fails = 0;
  logic [20:0] sb[$];
  logic [3:0]  v0, v1, v_m;
  logic        f0, f1, busy0, busy1, done0, done1, busy_m, done_m;
  logic [15:0] t0, t1, t_m;
  logic [4:0]  n0, n1, n_m;
  always #5 clk = ~clk;
  function automatic logic fn(input int m, input logic [3:0] v);
    return m == 0 ? ((v[1] | ~v[0]) & (v[3] ^ v[2])) : m == 1 ? 1'b1 : m == 2 ? 1'b0 : v[3];
  endfunction
  assign f0 = fn(mode, v0);
  assign f1 = fn(mode, v1);
  truth_table_sweeper #(.SETTLE_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .i_start(start && sel == 0), .i_abort(abort), .i_f_in(f0),
    .o_a(v0[3]), .o_b(v0[2]), .o_c(v0[1]), .o_d(v0[0]), .o_busy(busy0), .o_done(done0),
    .o_table_out(t0), .o_ones_count(n0));
  truth_table_sweeper #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .i_start(start && sel == 1), .i_abort(1'b0), .i_f_in(f1),
    .o_a(v1[3]), .o_b(v1[2]), .o_c(v1[1]), .o_d(v1[0]), .o_busy(busy1), .o_done(done1),
    .o_table_out(t1), .o_ones_count(n1));
  assign v_m    = sel == 1 ? v1 : v0;
  assign busy_m = sel == 1 ? busy1 : busy0;
  assign done_m = sel == 1 ? done1 : done0;
  assign t_m    = sel == 1 ? t1 : t0;
  assign n_m    = sel == 1 ? n1 : n0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input int s, input int m, input logic [15:0] et, input logic [4:0] en, input bit push);
    sel = s;
    mode = m;
    start = 1'b1;
    if (push) sb.push_back({en, et});
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run(input int s, input int pulse_k);
    int k = 0;
    int bad = 0;
    logic [20:0] e;
    while (!done_m && k < 200) begin
      if (k < 16 * (s + 1) && v_m !== 4'(k / (s + 1))) bad++;
      if (k == pulse_k) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    check("vector_steps", bad, 0);
    check("done_latency", k, 16 * (s + 1));
    check("busy_in_done", {31'd0, busy_m}, 1);
    check("vector_holds_15", {28'd0, v_m}, 15);
    if (sb.size() == 0) check("scoreboard_nonempty", 0, 1);
    else begin
      e = sb.pop_front();
      check("table_out", {16'd0, t_m}, {16'd0, e[15:0]});
      check("ones_count", {27'd0, n_m}, {27'd0, e[20:16]});
    end
    @(negedge clk);
    check("busy_after_done", {31'd0, busy_m}, 0);
    check("done_one_cycle", {31'd0, done_m}, 0);
  endtask
  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_done", {31'd0, done0}, 0);
    check("rst_table", {16'd0, t0}, 0);
    check("rst_ones", {27'd0, n0}, 0);
    check("rst_vec", {28'd0, v0}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    go(0, 0, 16'h0DD0, 5'd6, 1);
    check("busy_after_start", {31'd0, busy_m}, 1);
    run(2, -1);
    go(0, 3, 16'hFF00, 5'd8, 1);
    check("b2b_table_cleared", {16'd0, t_m}, 0);
    check("b2b_ones_cleared", {27'd0, n_m}, 0);
    run(2, 15);
    go(1, 1, 16'hFFFF, 5'd16, 1);
    run(1, -1);
    go(1, 2, 16'h0000, 5'd0, 1);
    run(1, -1);
    go(0, 0, 16'h0000, 5'd0, 0);
    repeat (21) @(negedge clk);
    check("abort_at_vec", {28'd0, v_m}, 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy_m}, 0);
    check("abort_table", {16'd0, t_m}, 16'h0050);
    check("abort_ones", {27'd0, n_m}, 2);
    check("abort_vec_hold", {28'd0, v_m}, 7);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_m) seen++;
      @(negedge clk);
    end
    check("abort_no_done", seen, 0);
    go(0, 0, 16'h0DD0, 5'd6, 1);
    run(2, -1);
    go(0, 3, 16'h0000, 5'd0, 0);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy0}, 0);
    check("arst_done", {31'd0, done0}, 0);
    check("arst_table", {16'd0, t0}, 0);
    check("arst_ones", {27'd0, n0}, 0);
    check("arst_vec", {28'd0, v0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (done0 || busy0) seen++;
      @(negedge clk);
    end
    check("arst_idle", seen, 0);
    go(0, 3, 16'hFF00, 5'd8, 1);
    run(2, -1);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
